// File: rtl/puf_readout_spi.sv
// -----------------------------------------------------------------------------
// puf_readout_spi
//   Captures a WIDTH-bit PUF response when the XOR PUF controller raises DONE,
//   then serves it to an SPI master (mode 0, MSB first) as an SPI slave.
//   SCLK and CS_N are sampled with CLK, which must run at least 4x faster than
//   SCLK.
//
// Ports
//   CLK         system clock, rising edge
//   RESET       asynchronous active-low reset
//   DONE        PUF controller done level; its rising edge captures a response
//   PUF_OUT_REG PUF response, stable while DONE is high
//   SCLK        SPI serial clock (asynchronous)
//   CS_N        SPI chip select, active low (asynchronous)
//   MISO        serial response data
//   VALID       a captured response has not yet been fully read
//   BUSY        FSM is not idle
//   FRAME_DONE  one-cycle pulse when the last response bit has been sampled
//   OVERRUN     sticky: a response arrived while a frame was being shifted out
// -----------------------------------------------------------------------------
module puf_readout_spi #(
  parameter int WIDTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DONE,
  input  logic [WIDTH-1:0] PUF_OUT_REG,
  input  logic             SCLK,
  input  logic             CS_N,
  output logic             MISO,
  output logic             VALID,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic             OVERRUN
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers for the SPI pins
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_reg, sclk_sync_next;
  logic [SYNC_STAGES-1:0] cs_sync_reg, cs_sync_next;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sclk_sync_next[gi] = SCLK;
        assign cs_sync_next[gi]   = CS_N;
      end else begin : g_rest
        assign sclk_sync_next[gi] = sclk_sync_reg[gi-1];
        assign cs_sync_next[gi]   = cs_sync_reg[gi-1];
      end
    end
  endgenerate

  logic sclk_s, cs_s;
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];

  // After reset the chains still hold their idle values. Edge detection is
  // held off until the chains and the previous-value flops have been refilled
  // from the real pins, so a CS_N that is already low after reset release is
  // not mistaken for a fresh falling edge.
  logic [SYNC_STAGES:0] fill_reg;
  logic                 sync_ok;
  assign sync_ok = fill_reg[SYNC_STAGES];

  logic sclk_prev_reg, cs_prev_reg, done_prev_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      fill_reg      <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      done_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= sclk_sync_next;
      cs_sync_reg   <= cs_sync_next;
      fill_reg      <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      done_prev_reg <= DONE;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, done_rise;
  assign sclk_rise = sync_ok &  sclk_s & ~sclk_prev_reg;
  assign sclk_fall = sync_ok & ~sclk_s &  sclk_prev_reg;
  assign cs_fall   = sync_ok & ~cs_s   &  cs_prev_reg;
  assign cs_rise   = sync_ok &  cs_s   & ~cs_prev_reg;
  assign done_rise = DONE & ~done_prev_reg;

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             valid_reg, valid_next;
  logic             frame_done_reg, frame_done_next;
  logic             overrun_reg, overrun_next;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_reg       <= '0;
      shreg_reg      <= '0;
      cnt_reg        <= '0;
      valid_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      data_reg       <= data_next;
      shreg_reg      <= shreg_next;
      cnt_reg        <= cnt_next;
      valid_reg      <= valid_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    shreg_next      = shreg_reg;
    cnt_next        = cnt_reg;
    valid_next      = valid_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;

    // A response can only be accepted while no frame is being loaded or
    // shifted; otherwise it is dropped and flagged.
    if (done_rise) begin
      if (state_reg == IDLE || state_reg == WAIT_CS) begin
        data_next  = PUF_OUT_REG;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        shreg_next = data_reg;
        cnt_next   = '0;
        state_next = cs_rise ? IDLE : SHIFT;
      end

      SHIFT: begin
        if (cs_rise) begin
          // Aborted frame: stored response and VALID stay as they are.
          state_next = IDLE;
        end else if (sclk_rise) begin
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            cnt_next        = CNT_W'(WIDTH);
            frame_done_next = 1'b1;
            valid_next      = 1'b0;
            state_next      = WAIT_CS;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        end
      end

      WAIT_CS: begin
        // Keep shifting zeros so extra SCLK cycles read back as 0.
        if (cs_rise) begin
          state_next = IDLE;
        end else if (sclk_fall) begin
          shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign MISO       = (state_reg == SHIFT || state_reg == WAIT_CS) ? shreg_reg[WIDTH-1] : 1'b0;
  assign VALID      = valid_reg;
  assign BUSY       = (state_reg != IDLE);
  assign FRAME_DONE = frame_done_reg;
  assign OVERRUN    = overrun_reg;

endmodule

// File: tb/tb_puf_readout_spi.sv
// -----------------------------------------------------------------------------
// tb_puf_readout_spi
//   Self-checking bench for puf_readout_spi: a table of frame scenarios, hand
//   sequences for overrun and reset-mid-frame, and randomized frames checked
//   against a response-level reference model.
// -----------------------------------------------------------------------------
module tb_puf_readout_spi;

  localparam int WIDTH = 128;
  localparam logic [WIDTH-1:0] PAT_A = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
  localparam logic [WIDTH-1:0] PAT_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [WIDTH-1:0] PAT_C = 128'hFFFF_0000_AAAA_5555_C3C3_3C3C_8001_7FFE;

  logic             CLK;
  logic             RESET;
  logic             DONE;
  logic [WIDTH-1:0] PUF_OUT_REG;
  logic             SCLK;
  logic             CS_N;
  logic             MISO;
  logic             VALID;
  logic             BUSY;
  logic             FRAME_DONE;
  logic             OVERRUN;

  puf_readout_spi #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DONE(DONE),
    .PUF_OUT_REG(PUF_OUT_REG),
    .SCLK(SCLK),
    .CS_N(CS_N),
    .MISO(MISO),
    .VALID(VALID),
    .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE),
    .OVERRUN(OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) fd_count++;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic capture(input logic [WIDTH-1:0] d);
    @(negedge CLK);
    PUF_OUT_REG = d;
    DONE = 1'b1;
    repeat (3) @(negedge CLK);
    DONE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic cs_low();
    @(negedge CLK);
    CS_N = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge CLK);
    CS_N = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  // Clocks nbits SCLK cycles (SCLK = CLK/8). MISO is sampled right before each
  // SCLK rise, as a mode-0 master would. Optionally pulses DONE with new data
  // just before bit done_at.
  task automatic shift_bits(input int nbits, input int done_at, input logic [WIDTH-1:0] done_data,
                            input logic [WIDTH-1:0] exp_data, output int bad, output int first_bad,
                            output bit busy_seen);
    bit expb;
    bad = 0;
    first_bad = -1;
    busy_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      expb = (i < WIDTH) ? exp_data[WIDTH-1-i] : 1'b0;
      if (MISO !== expb) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if (BUSY === 1'b1) busy_seen = 1'b1;
      if (i == done_at) begin
        PUF_OUT_REG = done_data;
        DONE = 1'b1;
      end
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      if (i == done_at) DONE = 1'b0;
      SCLK = 1'b0;
      repeat (4) @(negedge CLK);
    end
  endtask

  task automatic run_frame(input int nbits, input int done_at, input logic [WIDTH-1:0] done_data,
                           input logic [WIDTH-1:0] exp_data, output int bad, output int first_bad,
                           output int fd);
    int  fd0;
    bit  busy_seen;
    fd0 = fd_count;
    cs_low();
    shift_bits(nbits, done_at, done_data, exp_data, bad, first_bad, busy_seen);
    cs_high();
    fd = fd_count - fd0;
  endtask

  typedef struct {
    bit               cap;
    logic [WIDTH-1:0] data;
    int               nbits;
    logic [WIDTH-1:0] exp_data;
    bit               exp_valid_pre;
    bit               exp_valid_post;
    int               exp_fd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad, first_bad, fd, fd0;
    bit busy_seen;
    logic [WIDTH-1:0] m_data;
    bit m_valid, m_overrun;

    // empty read, basic read, abort after 37, restart from MSB, overclock
    vecs[0] = '{1'b0, '0,    128, '0,    1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, PAT_A, 128, PAT_A, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b1, PAT_B, 37,  PAT_B, 1'b1, 1'b1, 0};
    vecs[3] = '{1'b0, '0,    128, PAT_B, 1'b1, 1'b0, 1};
    vecs[4] = '{1'b1, PAT_C, 130, PAT_C, 1'b1, 1'b0, 1};

    RESET = 1'b0;
    DONE = 1'b0;
    PUF_OUT_REG = '0;
    SCLK = 1'b0;
    CS_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {MISO, VALID, BUSY, FRAME_DONE, OVERRUN}, '0);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);

    // ---------------- table-driven scenarios ----------------
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].cap) capture(vecs[v].data);
      check("valid_pre", VALID, vecs[v].exp_valid_pre);
      run_frame(vecs[v].nbits, -1, '0, vecs[v].exp_data, bad, first_bad, fd);
      $display("vec %0d: nbits=%0d bad_bits=%0d first_bad=%0d frame_done=%0d valid=%0b busy=%0b",
               v, vecs[v].nbits, bad, first_bad, fd, VALID, BUSY);
      check("miso_bad_bits", bad, 0);
      check("frame_done_count", fd, vecs[v].exp_fd);
      check("valid_post", VALID, vecs[v].exp_valid_post);
      check("busy_post", BUSY, 1'b0);
      check("overrun_clear", OVERRUN, 1'b0);
    end

    // ---------------- overrun ----------------
    capture(PAT_A);
    run_frame(128, 50, 128'h1, PAT_A, bad, first_bad, fd);
    $display("overrun frame: bad_bits=%0d frame_done=%0d overrun=%0b valid=%0b", bad, fd, OVERRUN, VALID);
    check("ovr_miso_bad_bits", bad, 0);
    check("ovr_frame_done", fd, 1);
    check("ovr_flag", OVERRUN, 1'b1);
    check("ovr_valid", VALID, 1'b0);
    run_frame(128, -1, '0, PAT_A, bad, first_bad, fd);
    $display("post-overrun frame: bad_bits=%0d frame_done=%0d overrun=%0b", bad, fd, OVERRUN);
    check("ovr_next_bad_bits", bad, 0);
    check("ovr_sticky", OVERRUN, 1'b1);

    // ---------------- randomized frames vs reference model ----------------
    m_data = PAT_A;
    m_valid = 1'b0;
    m_overrun = 1'b1;
    for (int t = 0; t < 16; t++) begin
      bit cap;
      int kind, nbits, done_at, exp_fd;
      logic [WIDTH-1:0] nd;
      cap = ($urandom % 2) == 1;
      if (cap) begin
        nd = {$urandom(), $urandom(), $urandom(), $urandom()};
        capture(nd);
        m_data = nd;
        m_valid = 1'b1;
      end
      check("rnd_valid_pre", VALID, m_valid);
      kind = $urandom % 3;
      if (kind == 0) nbits = WIDTH;
      else if (kind == 1) nbits = $urandom_range(3, WIDTH - 1);
      else nbits = $urandom_range(WIDTH + 1, WIDTH + 4);
      done_at = -1;
      if (($urandom % 4) == 0) begin
        done_at = $urandom_range(1, ((nbits < WIDTH) ? nbits : WIDTH) - 2);
        m_overrun = 1'b1;
      end
      run_frame(nbits, done_at, {$urandom(), $urandom(), $urandom(), $urandom()}, m_data,
                bad, first_bad, fd);
      exp_fd = (nbits >= WIDTH) ? 1 : 0;
      if (nbits >= WIDTH) m_valid = 1'b0;
      $display("rnd %0d: cap=%0b nbits=%0d done_at=%0d bad_bits=%0d frame_done=%0d valid=%0b overrun=%0b",
               t, cap, nbits, done_at, bad, fd, VALID, OVERRUN);
      check("rnd_miso_bad_bits", bad, 0);
      check("rnd_frame_done", fd, exp_fd);
      check("rnd_valid_post", VALID, m_valid);
      check("rnd_overrun", OVERRUN, m_overrun);
    end

    // ---------------- reset mid-frame ----------------
    capture(PAT_C);
    cs_low();
    shift_bits(60, -1, '0, PAT_C, bad, first_bad, busy_seen);
    check("rst_pre_bad_bits", bad, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_outputs_now", {MISO, VALID, BUSY, FRAME_DONE, OVERRUN}, '0);
    repeat (3) @(negedge CLK);
    check("rst_outputs_held", {MISO, VALID, BUSY, FRAME_DONE, OVERRUN}, '0);
    RESET = 1'b1;
    fd0 = fd_count;
    repeat (6) @(negedge CLK);
    // CS_N is still low: nothing may start until it is cycled.
    shift_bits(20, -1, '0, '0, bad, first_bad, busy_seen);
    $display("reset hold: bad_bits=%0d busy_seen=%0b frame_done=%0d", bad, busy_seen, fd_count - fd0);
    check("rst_hold_miso", bad, 0);
    check("rst_hold_busy", busy_seen, 1'b0);
    check("rst_hold_fd", fd_count - fd0, 0);
    cs_high();
    run_frame(128, -1, '0, '0, bad, first_bad, fd);
    $display("post-reset frame: bad_bits=%0d frame_done=%0d valid=%0b", bad, fd, VALID);
    check("rst_frame_bad_bits", bad, 0);
    check("rst_frame_done", fd, 1);
    check("rst_frame_valid", VALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_readout_spi.md
PUF_READOUT_SPI -- requirements
Module: puf_readout_spi

Interface
REQ-001 SHALL have parameter WIDTH, default 128, giving the PUF response width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for SCLK and CS_N.
REQ-003 SHALL have port CLK, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-low reset, with one clock only (CLK).
REQ-005 SHALL have port DONE, input, 1, level from the XOR PUF controller; capture is triggered by its rising edge.
REQ-006 SHALL have port PUF_OUT_REG, input, WIDTH, PUF response; stable while DONE is high.
REQ-007 SHALL have port SCLK, input, 1, SPI serial clock from the master; asynchronous to CLK.
REQ-008 SHALL have port CS_N, input, 1, SPI chip select, active-low; asynchronous to CLK.
REQ-009 SHALL have port MISO, output, 1, serial response data.
REQ-010 SHALL have port VALID, output, 1, captured response not yet fully read.
REQ-011 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port FRAME_DONE, output, 1, one-CLK pulse when the WIDTH-th bit has been sampled.
REQ-013 SHALL have port OVERRUN, output, 1, sticky flag: a new response was dropped.

Function
REQ-014 SHALL pass SCLK and CS_N through SYNC_STAGES flops (reset values SCLK=0, CS_N=1); all edge detection SHALL use the synchronized signals.
REQ-015 SHALL require CLK frequency >= 4x SCLK frequency; behaviour outside this limit is undefined.
REQ-016 SHALL detect a DONE rising edge as DONE=1 while a registered copy of DONE is 0.
REQ-017 SHALL, on a DONE rising edge in IDLE or WAIT_CS, load PUF_OUT_REG into DATA_REG and set VALID=1 on the next cycle.
REQ-018 SHALL, on a DONE rising edge in LOAD or SHIFT, leave DATA_REG unchanged and set OVERRUN=1.
REQ-019 SHALL implement the states IDLE, LOAD, SHIFT and WAIT_CS.
REQ-020 SHALL go IDLE->LOAD on a synchronized CS_N falling edge; in LOAD it SHALL copy DATA_REG to SHREG and clear BIT_CNT, then go to SHIFT on the next cycle.
REQ-021 SHALL use SPI mode 0, MSB first: MISO=SHREG[WIDTH-1] in SHIFT/WAIT_CS, master samples on SCLK rising, and SHREG shifts left with zero fill on each synchronized SCLK falling edge.
REQ-022 SHALL increment BIT_CNT on each synchronized SCLK rising edge in SHIFT; when BIT_CNT reaches WIDTH it SHALL pulse FRAME_DONE, clear VALID and go to WAIT_CS.
REQ-023 SHALL drive MISO=0 for extra SCLK edges in WAIT_CS after all WIDTH bits have been sent.
REQ-024 SHALL go WAIT_CS->IDLE on a synchronized CS_N rising edge.
REQ-025 SHALL abort on a CS_N rising edge in SHIFT before WIDTH bits: go to IDLE, keep VALID and DATA_REG unchanged, and give no FRAME_DONE; the next frame SHALL restart from the MSB.
REQ-026 SHALL, for a frame started with VALID=0, shift out the current DATA_REG contents with VALID held at 0.
REQ-027 SHALL, if a DONE rising edge and the final-bit completion occur in the same cycle, set OVERRUN, clear VALID and leave DATA_REG unchanged.
REQ-028 SHALL drive MISO=0 whenever the FSM is in IDLE or LOAD.

Reset
REQ-029 SHALL, on RESET=0 and independent of CLK, set: state IDLE, DATA_REG=0, SHREG=0, BIT_CNT=0, MISO=0, VALID=0, BUSY=0, FRAME_DONE=0, OVERRUN=0, synchronizers to idle values.
REQ-030 SHALL clear OVERRUN only by reset.
REQ-031 SHALL, when reset is asserted mid-frame, drop the frame; after release the FSM SHALL wait for a new CS_N falling edge even if CS_N is already low.

Verification
REQ-032 Basic read: DONE rises with PUF_OUT_REG=128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, then 128 SCLK cycles at CLK/8 -> MISO bits equal the pattern MSB first, FRAME_DONE pulses once, VALID goes 1->0.
REQ-033 Abort: CS_N rises after 37 bits -> BUSY=0, VALID=1, no FRAME_DONE; a second full frame returns all 128 bits from bit 127.
REQ-034 Overrun: DONE rises again during SHIFT with new data 128'h1 -> OVERRUN=1, the frame completes with the original data, and the next frame still returns the original data.
REQ-035 Overclock: 130 SCLK cycles in one frame -> the first 128 bits are correct, bits 129-130 are 0, and FRAME_DONE pulses exactly once.
REQ-036 Reset mid-frame: RESET=0 for 3 cycles at bit 60 with CS_N held low -> all outputs take reset values and no shifting occurs until CS_N goes high then low again.
REQ-037 Empty read: a frame is started after reset with no DONE -> MISO stays 0 for 128 bits, VALID=0, and FRAME_DONE pulses.
